// File: rtl/mips_regfile_wb.sv
// mips_regfile_wb: MIPS register file fed by the writeback-select mux.
//   Write: 1 cycle (visible after the rising edge); read: combinational.
//   No backpressure: a write is accepted on every enabled edge.
// Optional feature macro: REGFILE_WB_BYPASS_EN.
//   When defined, a same-cycle write is forwarded combinationally to a
//   read port at the same nonzero address.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   regwrite, wr_addr,    write enable / destination / data from WB
//   wr_data
//   rd_addr_a/b           source register numbers (rs, rt)
//   rd_data_a/b           operand values
//   wr_count              committed writes since reset, saturating at 16'hFFFF
module mips_regfile_wb #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [15:0]       wr_count
);

  localparam int NREG = 1 << ADDR_W;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [15:0]      wr_count_q;
  logic [15:0]      wr_count_d;
  logic             wr_en;

  // Writes to register 0 are dropped entirely: no storage update, no count.
  assign wr_en = regwrite && (wr_addr != '0);

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_en && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
      end
      wr_count_q <= wr_count_d;
    end
  end

  // Storage is cleared asynchronously, so the stored path already reads 0
  // during reset; only the forwarding path needs an explicit rst_n gate.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0) begin
      rd_data_a = regs_q[rd_addr_a];
    end
    if (rd_addr_b != '0) begin
      rd_data_b = regs_q[rd_addr_b];
    end
`ifdef REGFILE_WB_BYPASS_EN
    if (rst_n && wr_en && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if (rst_n && wr_en && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
`endif
  end

  assign wr_count = wr_count_q;

endmodule

// File: doc/mips_regfile_wb.md
Name: mips_regfile_wb

Overview:
- Register file for the MIPS datapath.
- Sits directly downstream of the writeback-select mux: consumes its output (ALU result vs. memory data) as write data.
- Supplies the two source operands to the ID stage and the ALU-source mux.
- Sequential write, combinational read, hardwired zero register.

Parameters:
- WIDTH, 32, data width of each register and of the write/read data ports.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- regwrite  input  1  write enable from WB-stage control.
- wr_addr  input  ADDR_W  destination register number (rd or rt, already selected upstream).
- wr_data  input  WIDTH  write data from the writeback-select mux.
- rd_addr_a  input  ADDR_W  source register rs.
- rd_addr_b  input  ADDR_W  source register rt.
- rd_data_a  output  WIDTH  contents of rs.
- rd_data_b  output  WIDTH  contents of rt.
- wr_count  output  16  number of committed (non-discarded) writes since reset, saturating.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every register to 0 and wr_count to 0.
  - While rst_n is low, rd_data_a/rd_data_b read 0 for every address and writes are ignored.
  - A rising clk edge that coincides with rst_n low performs no write.
- Write:
  - On rising clk with rst_n high, regwrite=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - The new value is visible on read ports after that edge (1-cycle write latency).
- Register 0:
  - Writes to address 0 are discarded, do not increment wr_count, and never affect storage.
  - Reads of address 0 always return 0.
- Read: purely combinational; rd_data_x = reg[rd_addr_x] (0 for address 0). Both ports are independent and may read the same address.
- regwrite=0: no state change; wr_data and wr_addr are don't-care.
- wr_count:
  - Increments by 1 on every committed write.
  - Saturates at 16'hFFFF (no wrap).
  - Resets to 0 only via rst_n.
- Same-cycle read/write to the same nonzero address: governed by the optional feature below.
- No X propagation: storage never holds X after the first reset. Unused or unknown address bits are not permitted (bench drives them legally).

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: internal write-before-read forwarding. When regwrite=1, wr_addr!=0, rst_n=1 and rd_addr_x==wr_addr, rd_data_x = wr_data combinationally in the same cycle. This lets the pipeline's ID stage read a value written by WB in the same cycle without a stall.
- Not defined: read ports always show the stored (pre-edge) value. The new value appears only after the rising edge, and hazard handling is the forwarding unit's responsibility.
- Register-0 rule and reset rule hold in both builds.

Test Plan:
- Reset: drive rst_n=0 mid-simulation after writing reg[5]=32'hDEADBEEF -> rd_data_a(addr 5) reads 0 immediately (no clock edge needed) and wr_count=0.
- Basic write/read: regwrite=1, wr_addr=8, wr_data=32'h0000_1234, one edge; then rd_addr_a=8, rd_addr_b=8 -> both ports read 32'h0000_1234, wr_count=1.
- Zero register: regwrite=1, wr_addr=0, wr_data=32'hFFFF_FFFF, one edge -> rd_data_a(addr 0)=0, wr_count unchanged.
- Same-cycle read/write:
  - Setup: reg[3]=32'h1111_1111; in one cycle regwrite=1, wr_addr=3, wr_data=32'h2222_2222, rd_addr_a=3.
  - Before the edge: rd_data_a=32'h2222_2222 with REGFILE_WB_BYPASS_EN, 32'h1111_1111 without.
  - After the edge: 32'h2222_2222 in both builds.
- Full sweep and port independence:
  - Write reg[i]=i*32'h0101_0101 for i=1..31, then read all pairs (i,31-i) -> correct values on both ports; wr_count=31.
  - regwrite=0 with a random wr_addr/wr_data for 10 cycles -> no change.
- Saturation: force 65,540 committed writes -> wr_count holds 16'hFFFF; regwrite coincident with rst_n low -> no write occurs.
